// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths, defaults and types for the register file write arbiter.
package regfile_write_arbiter_pkg;

  localparam int unsigned XLEN               = 32;
  localparam int unsigned REG_ADDR_W         = 5;
  localparam int unsigned NUM_REGS           = 32;
  localparam int unsigned LL_FIFO_DEPTH_DFLT = 2;
  localparam int unsigned STARVE_LIMIT_DFLT  = 4;
  localparam logic [REG_ADDR_W-1:0] REG_X0   = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wr_req_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_FIFO = 2'd2,
    SRC_BYP  = 2'd3
  } src_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback, long-latency result, issue and register-file write signals of the arbiter.
interface regfile_write_arbiter_if;
  import regfile_write_arbiter_pkg::*;

  logic                  wb_valid_i;
  logic [REG_ADDR_W-1:0] wb_rd_addr_i;
  logic [XLEN-1:0]       wb_rd_data_i;
  logic                  ll_valid_i;
  logic                  ll_ready_o;
  logic [REG_ADDR_W-1:0] ll_rd_addr_i;
  logic [XLEN-1:0]       ll_rd_data_i;
  logic                  issue_valid_i;
  logic [REG_ADDR_W-1:0] issue_rd_addr_i;
  logic                  issue_conflict_o;
  logic [NUM_REGS-1:0]   busy_o;
  logic                  wb_stall_o;
  logic [REG_ADDR_W-1:0] rd_addr_o;
  logic [XLEN-1:0]       rd_data_o;
  logic                  reg_write_en_o;

  modport slave (
    input  wb_valid_i, wb_rd_addr_i, wb_rd_data_i,
    input  ll_valid_i, ll_rd_addr_i, ll_rd_data_i,
    input  issue_valid_i, issue_rd_addr_i,
    output ll_ready_o, issue_conflict_o, busy_o, wb_stall_o,
    output rd_addr_o, rd_data_o, reg_write_en_o
  );

  modport master (
    output wb_valid_i, wb_rd_addr_i, wb_rd_data_i,
    output ll_valid_i, ll_rd_addr_i, ll_rd_data_i,
    output issue_valid_i, issue_rd_addr_i,
    input  ll_ready_o, issue_conflict_o, busy_o, wb_stall_o,
    input  rd_addr_o, rd_data_o, reg_write_en_o
  );

endinterface

// File: rtl/regfile_write_arbiter_wb_sync_fifo.sv
// Small synchronous FIFO holding long-latency results; head is visible without a pop.
module wb_sync_fifo #(
  parameter  int unsigned WIDTH = 37,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Storage is not reset: count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single driver of the register file write port: pipeline writeback first, then buffered
// or bypassed long-latency results; also keeps the busy scoreboard for the hazard unit.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter  int unsigned LL_FIFO_DEPTH = LL_FIFO_DEPTH_DFLT,
  parameter  int unsigned STARVE_LIMIT  = STARVE_LIMIT_DFLT,
  localparam int unsigned CW            = $clog2(LL_FIFO_DEPTH) + 1,
  localparam int unsigned SW            = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_write_arbiter_if.slave  bus
);

  wr_req_t             wb_req, ll_req, fifo_head, sel_req;
  src_e                sel;
  logic [CW-1:0]       fifo_count;
  logic                fifo_empty, fifo_push, fifo_pop;
  logic                wb_sel, ll_acc;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic                stall_q, wen_q;
  logic [REG_ADDR_W-1:0] rd_addr_q;
  logic [XLEN-1:0]       rd_data_q;

  assign wb_req  = '{addr: bus.wb_rd_addr_i, data: bus.wb_rd_data_i};
  assign ll_req  = '{addr: bus.ll_rd_addr_i, data: bus.ll_rd_data_i};
  assign wb_sel  = bus.wb_valid_i && (bus.wb_rd_addr_i != REG_X0);
  assign ll_acc  = bus.ll_valid_i && bus.ll_ready_o;

  assign bus.ll_ready_o = ~rst & (fifo_count < CW'(LL_FIFO_DEPTH));

  always_comb begin
    sel     = SRC_NONE;
    sel_req = fifo_head;
    if (wb_sel) begin
      sel     = SRC_WB;
      sel_req = wb_req;
    end else if (!fifo_empty) begin
      sel     = SRC_FIFO;
      sel_req = fifo_head;
    end else if (ll_acc && (ll_req.addr != REG_X0)) begin
      sel     = SRC_BYP;
      sel_req = ll_req;
    end
  end

  // Results to x0 are accepted but vanish here rather than occupying a FIFO slot.
  assign fifo_pop  = (sel == SRC_FIFO);
  assign fifo_push = ll_acc && (ll_req.addr != REG_X0) && (sel != SRC_BYP);

  wb_sync_fifo #(
    .WIDTH ($bits(wr_req_t)),
    .DEPTH (LL_FIFO_DEPTH)
  ) u_ll_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (ll_req),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  // A new issue to the same register outranks the clear from an older result landing.
  always_comb begin
    busy_d = busy_q;
    if ((sel == SRC_FIFO) || (sel == SRC_BYP)) busy_d[sel_req.addr] = 1'b0;
    if (bus.issue_valid_i && (bus.issue_rd_addr_i != REG_X0)) busy_d[bus.issue_rd_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || fifo_pop) begin
      starve_d = '0;
    end else if ((sel == SRC_WB) && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q     <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      busy_q    <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
    end else begin
      wen_q <= (sel != SRC_NONE);
      if (sel != SRC_NONE) begin
        rd_addr_q <= sel_req.addr;
        rd_data_q <= sel_req.data;
      end
      busy_q   <= busy_d;
      starve_q <= starve_d;
      stall_q  <= (starve_d == SW'(STARVE_LIMIT));
    end
  end

  assign bus.issue_conflict_o = bus.issue_valid_i && (bus.issue_rd_addr_i != REG_X0)
                                && busy_q[bus.issue_rd_addr_i];
  assign bus.busy_o         = busy_q;
  assign bus.wb_stall_o     = stall_q;
  assign bus.rd_addr_o      = rd_addr_q;
  assign bus.rd_data_o      = rd_data_q;
  assign bus.reg_write_en_o = wen_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expected values.
module tb_regfile_write_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_valid_i      = 1'b0;
    bus.wb_rd_addr_i    = 5'd0;
    bus.wb_rd_data_i    = 32'h0;
    bus.ll_valid_i      = 1'b0;
    bus.ll_rd_addr_i    = 5'd0;
    bus.ll_rd_data_i    = 32'h0;
    bus.issue_valid_i   = 1'b0;
    bus.issue_rd_addr_i = 5'd0;
  endtask

  task automatic chk_port(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_wen"}, 32'(bus.reg_write_en_o), 32'(en));
    chk({tag, "_addr"}, 32'(bus.rd_addr_o), 32'(a));
    chk({tag, "_data"}, bus.rd_data_o, d);
  endtask

  logic [4:0]  ll_a [3] = '{5'd6, 5'd7, 5'd8};
  logic [31:0] ll_d [3] = '{32'h6666_0006, 32'h7777_0007, 32'h8888_0008};

  initial begin
    int  idx;
    int  stall_at;
    logic acc;
    logic seen_full;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    idle_inputs();

    // Reset state
    #12;
    chk_port("rst0", 1'b0, 5'd0, 32'h0);
    chk("rst0_busy", bus.busy_o, 32'h0);
    chk("rst0_stall", 32'(bus.wb_stall_o), 32'd0);
    chk("rst0_ready", 32'(bus.ll_ready_o), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(bus.ll_ready_o), 32'd1);

    // Plain writeback
    bus.wb_valid_i = 1'b1; bus.wb_rd_addr_i = 5'd1; bus.wb_rd_data_i = 32'hDEAD_BEEF;
    step();
    chk_port("wb_x1", 1'b1, 5'd1, 32'hDEAD_BEEF);
    idle_inputs();
    step();
    chk_port("idle_hold", 1'b0, 5'd1, 32'hDEAD_BEEF);

    // wb to x0 dropped, LL bypass takes the port
    bus.wb_valid_i = 1'b1; bus.wb_rd_addr_i = 5'd0; bus.wb_rd_data_i = 32'hFFFF_FFFF;
    bus.ll_valid_i = 1'b1; bus.ll_rd_addr_i = 5'd3; bus.ll_rd_data_i = 32'hCAFE_F00D;
    step();
    chk_port("byp_x3", 1'b1, 5'd3, 32'hCAFE_F00D);
    idle_inputs();
    step();
    chk("byp_fifo_empty", 32'(bus.reg_write_en_o), 32'd0);

    // Issue x5, LL x5 queued behind wb x2
    bus.issue_valid_i = 1'b1; bus.issue_rd_addr_i = 5'd5;
    #1;
    chk("iss5_conflict", 32'(bus.issue_conflict_o), 32'd0);
    step();
    idle_inputs();
    chk("iss5_busy", bus.busy_o, 32'h0000_0020);
    bus.wb_valid_i = 1'b1; bus.wb_rd_addr_i = 5'd2; bus.wb_rd_data_i = 32'h0000_0022;
    bus.ll_valid_i = 1'b1; bus.ll_rd_addr_i = 5'd5; bus.ll_rd_data_i = 32'h1234_5678;
    step();
    idle_inputs();
    chk_port("q_x2", 1'b1, 5'd2, 32'h0000_0022);
    chk("q_busy_held", bus.busy_o, 32'h0000_0020);
    step();
    chk_port("q_x5", 1'b1, 5'd5, 32'h1234_5678);
    chk("q_busy_clr", bus.busy_o, 32'h0);

    // WAW conflict and issue to x0
    bus.issue_valid_i = 1'b1; bus.issue_rd_addr_i = 5'd4;
    step();
    #1;
    chk("waw_conflict", 32'(bus.issue_conflict_o), 32'd1);
    step();
    bus.issue_rd_addr_i = 5'd0;
    #1;
    chk("x0_conflict", 32'(bus.issue_conflict_o), 32'd0);
    step();
    idle_inputs();
    chk("x0_busy", bus.busy_o, 32'h0000_0010);

    // Starvation: wb every cycle while LL x6,x7,x8 arrive
    idx = 0; stall_at = 0; seen_full = 1'b0;
    bus.wb_valid_i = 1'b1; bus.wb_rd_addr_i = 5'd9;
    bus.ll_valid_i = 1'b1; bus.ll_rd_addr_i = ll_a[0]; bus.ll_rd_data_i = ll_d[0];
    for (int c = 1; c <= 20 && stall_at == 0; c++) begin
      bus.wb_rd_data_i = 32'h9000_0000 + 32'(c);
      acc = bus.ll_valid_i & bus.ll_ready_o;
      step();
      if (acc) begin
        idx++;
        if (idx < 3) begin
          bus.ll_rd_addr_i = ll_a[idx]; bus.ll_rd_data_i = ll_d[idx];
        end
      end
      chk("starve_wb_addr", 32'(bus.rd_addr_o), 32'd9);
      if (!bus.ll_ready_o) seen_full = 1'b1;
      if (bus.wb_stall_o) stall_at = c;
    end
    chk("starve_full", 32'(seen_full), 32'd1);
    chk("starve_accepted", 32'(idx), 32'd2);
    chk("stall_cycle", 32'(stall_at), 32'd5);

    bus.wb_valid_i = 1'b0;
    step();
    chk_port("drain_x6", 1'b1, 5'd6, ll_d[0]);
    chk("drain_stall_clr", 32'(bus.wb_stall_o), 32'd0);
    acc = bus.ll_valid_i & bus.ll_ready_o;
    step();
    if (acc) idx++;
    bus.ll_valid_i = 1'b0;
    chk("x8_accepted", 32'(idx), 32'd3);
    chk_port("drain_x7", 1'b1, 5'd7, ll_d[1]);
    step();
    chk_port("drain_x8", 1'b1, 5'd8, ll_d[2]);
    step();
    chk("drain_done", 32'(bus.reg_write_en_o), 32'd0);

    // Reset mid-operation with a queued LL result and a pending write
    bus.wb_valid_i = 1'b1; bus.wb_rd_addr_i = 5'd10; bus.wb_rd_data_i = 32'hAAAA_000A;
    bus.ll_valid_i = 1'b1; bus.ll_rd_addr_i = 5'd11; bus.ll_rd_data_i = 32'hBBBB_000B;
    step();
    idle_inputs();
    chk_port("pre_rst_x10", 1'b1, 5'd10, 32'hAAAA_000A);
    #3;
    rst = 1'b1;
    #1;
    chk_port("mid_rst", 1'b0, 5'd0, 32'h0);
    chk("mid_rst_busy", bus.busy_o, 32'h0);
    chk("mid_rst_ready", 32'(bus.ll_ready_o), 32'd0);
    #2;
    rst = 1'b0;
    step();
    chk("post_rst_nowrite", 32'(bus.reg_write_en_o), 32'd0);
    chk("post_rst_ready", 32'(bus.ll_ready_o), 32'd1);
    step();
    chk("post_rst_fifo_gone", 32'(bus.reg_write_en_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
